// File: rtl/minn_preamble_inserter.sv
// Minn preamble inserter (transmit side).
// Emits one frame per start: optional cyclic prefix (-A tail), an NFFT-sample preamble with
// quarter pattern [+A, +A, -A, -A] read from an internal sequence RAM, then a payload passed
// through with valid/ready flow control. The sequence RAM is writable only while idle.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   seq_we/seq_addr/seq_i/seq_q       sequence RAM write port (ignored while busy)
//   start, payload_len                frame request and payload sample count
//   s_valid/s_ready, s_ch*_*          payload input stream
//   out_valid/out_ready, out_ch*_*    output stream (dual antenna I/Q)
//   preamble_start                    marks the first preamble sample
//   busy                              frame in progress (including the undelivered last sample)
module minn_preamble_inserter #(
  parameter int unsigned NFFT   = 2048,
  parameter int unsigned W_IN   = 12,
  parameter int unsigned CP_LEN = 0,
  parameter int unsigned LEN_W  = 16,
  localparam int unsigned Q     = NFFT / 4,
  localparam int unsigned AW    = $clog2(Q)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seq_we,
  input  logic [AW-1:0]    seq_addr,
  input  logic [W_IN-1:0]  seq_i,
  input  logic [W_IN-1:0]  seq_q,
  input  logic             start,
  input  logic [LEN_W-1:0] payload_len,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W_IN-1:0]  s_ch0_i,
  input  logic [W_IN-1:0]  s_ch0_q,
  input  logic [W_IN-1:0]  s_ch1_i,
  input  logic [W_IN-1:0]  s_ch1_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_IN-1:0]  out_ch0_i,
  output logic [W_IN-1:0]  out_ch0_q,
  output logic [W_IN-1:0]  out_ch1_i,
  output logic [W_IN-1:0]  out_ch1_q,
  output logic             preamble_start,
  output logic             busy
);

  // CP starts CP_LEN entries before the end of the quarter; with CP_LEN=0 this wraps to 0.
  localparam logic [AW-1:0]   FirstAddr = AW'(Q - CP_LEN);
  localparam logic [AW-1:0]   LastAddr  = AW'(Q - 1);
  localparam logic [W_IN-1:0] MinVal    = {1'b1, {(W_IN-1){1'b0}}};
  localparam logic [W_IN-1:0] MaxVal    = {1'b0, {(W_IN-1){1'b1}}};

  typedef enum logic [1:0] {StIdle, StCp, StPre, StPay} state_e;

  function automatic logic [W_IN-1:0] neg_sat(input logic [W_IN-1:0] x);
    if (x == MinVal) return MaxVal;
    return -x;
  endfunction

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [1:0]        quarter_q, quarter_d;
  logic              done_q, done_d;       // all preamble reads issued, draining stage 1
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  pay_cnt_q, pay_cnt_d;

  // Stage 1: RAM read data plus per-sample control.
  logic              s1_valid_q, s1_valid_d;
  logic              s1_neg_q, s1_neg_d;
  logic              s1_pstart_q, s1_pstart_d;
  logic [2*W_IN-1:0] rd_data_q;
  logic [2*W_IN-1:0] seq_mem [Q];

  // Stage 2: output register.
  logic              out_valid_q, out_valid_d;
  logic              out_pstart_q, out_pstart_d;
  logic [W_IN-1:0]   o0i_q, o0i_d, o0q_q, o0q_d, o1i_q, o1i_d, o1q_q, o1q_d;

  logic              out_adv, s1_adv, pay_acc;
  logic              issue, iss_neg, iss_pstart, rd_bypass;
  logic [AW-1:0]     rd_addr;
  logic [W_IN-1:0]   pre_i, pre_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      quarter_q <= '0;
      done_q    <= 1'b0;
      len_q     <= '0;
      pay_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      quarter_q <= quarter_d;
      done_q    <= done_d;
      len_q     <= len_d;
      pay_cnt_q <= pay_cnt_d;
    end
  end

  // Output / control decode.
  always_comb begin
    busy       = (state_q != StIdle) || out_valid_q;
    out_adv    = !out_valid_q || out_ready;
    s1_adv     = !s1_valid_q || out_adv;
    s_ready    = (state_q == StPay) && out_adv;
    pay_acc    = s_valid && s_ready;
    issue      = 1'b0;
    rd_addr    = addr_q;
    iss_neg    = 1'b0;
    iss_pstart = 1'b0;
    unique case (state_q)
      StIdle: begin
        // First read is issued in the start cycle itself to reach 2-cycle latency.
        rd_addr    = FirstAddr;
        iss_neg    = (CP_LEN != 0);
        iss_pstart = (CP_LEN == 0);
        issue      = start && !out_valid_q;
      end
      StCp: begin
        iss_neg = 1'b1;
        issue   = s1_adv;
      end
      StPre: begin
        iss_neg    = quarter_q[1];
        iss_pstart = (quarter_q == 2'd0) && (addr_q == '0);
        issue      = s1_adv && !done_q;
      end
      default: ;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    quarter_d = quarter_q;
    done_d    = done_q;
    len_d     = len_q;
    pay_cnt_d = pay_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          len_d     = payload_len;
          pay_cnt_d = '0;
          done_d    = 1'b0;
          quarter_d = '0;
          addr_d    = FirstAddr + 1'b1;
          if (CP_LEN == 0 || FirstAddr == LastAddr) state_d = StPre;
          else                                      state_d = StCp;
        end
      end
      StCp: begin
        if (issue) begin
          addr_d = addr_q + 1'b1;
          if (addr_q == LastAddr) state_d = StPre;
        end
      end
      StPre: begin
        if (issue) begin
          addr_d = addr_q + 1'b1;
          if (addr_q == LastAddr) begin
            quarter_d = quarter_q + 1'b1;
            if (quarter_q == 2'd3) done_d = 1'b1;
          end
        end else if (done_q && s1_adv) begin
          // Last preamble sample moves into the output register on this edge.
          state_d = (len_q == '0) ? StIdle : StPay;
        end
      end
      StPay: begin
        if (pay_acc) begin
          pay_cnt_d = pay_cnt_q + 1'b1;
          if (pay_cnt_q == len_q - 1'b1) state_d = StIdle;
        end
      end
      default: ;
    endcase
  end

  // Sequence RAM and its read register; contents are intentionally not reset.
  assign rd_bypass = seq_we && !busy && (seq_addr == rd_addr);

  always_ff @(posedge clk) begin
    if (seq_we && !busy) seq_mem[seq_addr] <= {seq_i, seq_q};
    // Held while stage 1 stalls so a prefetched sample is never lost.
    if (issue) rd_data_q <= rd_bypass ? {seq_i, seq_q} : seq_mem[rd_addr];
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_neg_d    = s1_neg_q;
    s1_pstart_d = s1_pstart_q;
    if (s1_adv) begin
      s1_valid_d  = issue;
      s1_neg_d    = iss_neg;
      s1_pstart_d = iss_pstart;
    end
  end

  assign pre_i = s1_neg_q ? neg_sat(rd_data_q[2*W_IN-1:W_IN]) : rd_data_q[2*W_IN-1:W_IN];
  assign pre_q = s1_neg_q ? neg_sat(rd_data_q[W_IN-1:0])      : rd_data_q[W_IN-1:0];

  always_comb begin
    out_valid_d  = out_valid_q;
    out_pstart_d = out_pstart_q;
    o0i_d        = o0i_q;
    o0q_d        = o0q_q;
    o1i_d        = o1i_q;
    o1q_d        = o1q_q;
    if (out_adv) begin
      out_valid_d  = 1'b0;
      out_pstart_d = 1'b0;
      if (pay_acc) begin
        out_valid_d = 1'b1;
        o0i_d       = s_ch0_i;
        o0q_d       = s_ch0_q;
        o1i_d       = s_ch1_i;
        o1q_d       = s_ch1_q;
      end else if (s1_valid_q) begin
        out_valid_d  = 1'b1;
        out_pstart_d = s1_pstart_q;
        o0i_d        = pre_i;
        o0q_d        = pre_q;
        o1i_d        = pre_i;
        o1q_d        = pre_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_neg_q     <= 1'b0;
      s1_pstart_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_pstart_q <= 1'b0;
      o0i_q        <= '0;
      o0q_q        <= '0;
      o1i_q        <= '0;
      o1q_q        <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_neg_q     <= s1_neg_d;
      s1_pstart_q  <= s1_pstart_d;
      out_valid_q  <= out_valid_d;
      out_pstart_q <= out_pstart_d;
      o0i_q        <= o0i_d;
      o0q_q        <= o0q_d;
      o1i_q        <= o1i_d;
      o1q_q        <= o1q_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign preamble_start = out_pstart_q;
  assign out_ch0_i      = o0i_q;
  assign out_ch0_q      = o0q_q;
  assign out_ch1_i      = o1i_q;
  assign out_ch1_q      = o1q_q;

endmodule

// File: tb/tb_minn_preamble_inserter.sv
module tb_minn_preamble_inserter;
  localparam int NFFT = 16;
  localparam int W    = 12;
  localparam int CP   = 2;
  localparam int LW   = 16;
  localparam int Q    = NFFT / 4;
  localparam int AW   = 2;

  logic                clk = 1'b0;
  logic                rst, seq_we, start, s_valid, s_ready, out_valid, out_ready;
  logic                preamble_start, busy;
  logic [AW-1:0]       seq_addr;
  logic signed [W-1:0] seq_i, seq_q, s_ch0_i, s_ch0_q, s_ch1_i, s_ch1_q;
  logic signed [W-1:0] out_ch0_i, out_ch0_q, out_ch1_i, out_ch1_q;
  logic [LW-1:0]       payload_len;

  always #5 clk = ~clk;

  minn_preamble_inserter #(.NFFT(NFFT), .W_IN(W), .CP_LEN(CP), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .seq_we(seq_we), .seq_addr(seq_addr), .seq_i(seq_i),
    .seq_q(seq_q), .start(start), .payload_len(payload_len), .s_valid(s_valid),
    .s_ready(s_ready), .s_ch0_i(s_ch0_i), .s_ch0_q(s_ch0_q), .s_ch1_i(s_ch1_i),
    .s_ch1_q(s_ch1_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch0_i(out_ch0_i), .out_ch0_q(out_ch0_q), .out_ch1_i(out_ch1_i),
    .out_ch1_q(out_ch1_q), .preamble_start(preamble_start), .busy(busy)
  );

  typedef struct {
    int i0; int q0; int i1; int q1; int ps;
  } exp_t;

  exp_t exp_q[$];
  int   pay_i0[$], pay_q0[$], pay_i1[$], pay_q1[$];
  int   mi[Q], mq[Q];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference negation: exact except the most negative value, which clips to the maximum.
  function automatic int mneg(input int x);
    int r;
    r = -x;
    if (r > (1 << (W - 1)) - 1) r = (1 << (W - 1)) - 1;
    return r;
  endfunction

  function automatic int rnd_sample();
    return int'($urandom_range(4095)) - 2048;
  endfunction

  task automatic write_seq(input int a, input int vi, input int vq);
    seq_we   = 1'b1;
    seq_addr = AW'(a);
    seq_i    = W'(vi);
    seq_q    = W'(vq);
    @(posedge clk);
    #1;
    seq_we = 1'b0;
    mi[a]  = vi;
    mq[a]  = vq;
  endtask

  task automatic push_s(input int i0, input int q0, input int i1, input int q1, input int ps);
    exp_t e;
    e.i0 = i0; e.q0 = q0; e.i1 = i1; e.q1 = q1; e.ps = ps;
    exp_q.push_back(e);
  endtask

  task automatic drive_pay(input int pidx, input int len, input int vld_pct);
    if (pidx < len && int'($urandom_range(99)) < vld_pct) begin
      s_valid = 1'b1;
      s_ch0_i = W'(pay_i0[pidx]);
      s_ch0_q = W'(pay_q0[pidx]);
      s_ch1_i = W'(pay_i1[pidx]);
      s_ch1_q = W'(pay_q1[pidx]);
    end else begin
      s_valid = 1'b0;
    end
  endtask

  // One frame: expectations pushed up front, monitor consumes them as samples are accepted.
  task automatic run_frame(input int len, input int rdy_pct, input int vld_pct,
                           input int inj_it, input int rst_acc, input bit tim, input bit dir);
    int  total, pidx, bad, v, w, a;
    bit  acc, done;
    exp_q.delete();
    pay_i0.delete(); pay_q0.delete(); pay_i1.delete(); pay_q1.delete();
    for (int k = 0; k < CP; k++) begin
      v = mneg(mi[Q - CP + k]);
      w = mneg(mq[Q - CP + k]);
      push_s(v, w, v, w, 0);
    end
    for (int n = 0; n < NFFT; n++) begin
      a = n % Q;
      if (n / Q < 2) begin v = mi[a]; w = mq[a]; end
      else begin v = mneg(mi[a]); w = mneg(mq[a]); end
      push_s(v, w, v, w, (n == 0) ? 1 : 0);
    end
    for (int p = 0; p < len; p++) begin
      if (dir) begin
        pay_i0.push_back(10 + p); pay_q0.push_back(-10 - p);
        pay_i1.push_back(20 + p); pay_q1.push_back(30 + p);
      end else begin
        pay_i0.push_back(rnd_sample()); pay_q0.push_back(rnd_sample());
        pay_i1.push_back(rnd_sample()); pay_q1.push_back(rnd_sample());
      end
      push_s(pay_i0[p], pay_q0[p], pay_i1[p], pay_q1[p], 0);
    end
    total       = CP + NFFT + len;
    pidx        = 0;
    bad         = 0;
    done        = 1'b0;
    start       = 1'b1;
    payload_len = LW'(len);
    out_ready   = (int'($urandom_range(99)) < rdy_pct);
    drive_pay(pidx, len, vld_pct);
    for (int it = 1; it <= 3000 && !done; it++) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      start  = 1'b0;
      seq_we = 1'b0;
      if (acc) pidx++;
      if (s_ready && (total - exp_q.size()) < CP + NFFT - 1) bad++;
      if (tim && it == 1) begin
        check("valid_at_t1", int'(out_valid), 0);
        check("busy_rise", int'(busy), 1);
      end
      if (tim && it == 2) check("valid_at_t2", int'(out_valid), 1);
      if (it == inj_it) begin
        start       = 1'b1;
        payload_len = LW'(5);
        seq_we      = 1'b1;
        seq_addr    = AW'(1);
        seq_i       = W'(-77);
        seq_q       = W'(55);
      end
      if (rst_acc > 0 && (total - exp_q.size()) == rst_acc) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pstart", int'(preamble_start), 0);
        check("rst_s_ready", int'(s_ready), 0);
        exp_q.delete();
        done = 1'b1;
      end
      out_ready = (int'($urandom_range(99)) < rdy_pct);
      drive_pay(pidx, len, vld_pct);
      if (exp_q.size() == 0 && !done) begin
        done = 1'b1;
        check("busy_fall", int'(busy), 0);
        check("valid_after_frame", int'(out_valid), 0);
        check("payload_accepted", pidx, len);
        if (tim) check("frame_cycles", it, total + 2);
      end
    end
    check("frame_timeout", exp_q.size(), 0);
    check("s_ready_outside_pay", bad, 0);
    exp_q.delete();
    s_valid   = 1'b0;
    out_ready = 1'b1;
  endtask

  // Monitor: compares every accepted output sample and checks hold-while-stalled.
  initial begin
    exp_t e;
    bit   pend;
    int   h0i, h0q, h1i, h1q, hps;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("stall_valid_hold", int'(out_valid), 1);
          check("stall_data_hold", int'(int'(out_ch0_i) == h0i && int'(out_ch0_q) == h0q &&
                int'(out_ch1_i) == h1i && int'(out_ch1_q) == h1q &&
                int'(preamble_start) == hps), 1);
        end
        pend = 1'b0;
        if (out_valid) begin
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              check("sample_expected", exp_q.size(), 1);
            end else begin
              e = exp_q.pop_front();
              check("ch0_i", int'(out_ch0_i), e.i0);
              check("ch0_q", int'(out_ch0_q), e.q0);
              check("ch1_i", int'(out_ch1_i), e.i1);
              check("ch1_q", int'(out_ch1_q), e.q1);
              check("preamble_start", int'(preamble_start), e.ps);
            end
          end else begin
            h0i = int'(out_ch0_i); h0q = int'(out_ch0_q);
            h1i = int'(out_ch1_i); h1q = int'(out_ch1_q);
            hps = int'(preamble_start);
            pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; seq_we = 1'b0; seq_addr = '0; seq_i = '0; seq_q = '0;
    payload_len = '0; s_valid = 1'b0; out_ready = 1'b1;
    s_ch0_i = '0; s_ch0_q = '0; s_ch1_i = '0; s_ch1_q = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_pstart", int'(preamble_start), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_s_ready", int'(s_ready), 0);
    check("reset_ch0_i", int'(out_ch0_i), 0);
    check("reset_ch0_q", int'(out_ch0_q), 0);
    check("reset_ch1_i", int'(out_ch1_i), 0);
    check("reset_ch1_q", int'(out_ch1_q), 0);
    rst = 1'b0;

    for (int a = 0; a < Q; a++) write_seq(a, a + 1, -(a + 1));
    run_frame(0, 100, 100, 0, 0, 1'b1, 1'b0);            // basic frame
    run_frame(3, 100, 100, 0, 0, 1'b1, 1'b1);            // payload 10,11,12
    write_seq(0, -2048, -2048);                          // saturating negation
    run_frame(0, 100, 100, 0, 0, 1'b1, 1'b0);
    write_seq(0, 1, -1);
    repeat (3) run_frame(0, 50, 100, 0, 0, 1'b0, 1'b0);  // random backpressure
    run_frame(2, 100, 100, 6, 0, 1'b0, 1'b0);            // ignored start/seq_we mid-frame
    run_frame(0, 100, 100, 0, 0, 1'b1, 1'b0);            // read-back of original RAM
    run_frame(0, 100, 100, 0, CP + 7, 1'b0, 1'b0);       // reset at preamble sample 7
    run_frame(0, 100, 100, 0, 0, 1'b1, 1'b0);
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < Q; a++) write_seq(a, rnd_sample(), rnd_sample());
      run_frame(int'($urandom_range(5)), int'($urandom_range(100, 30)),
                int'($urandom_range(100, 30)), 0, 0, 1'b0, 1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
